// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Five-state (IDLE, DECODE, EXEC, MEM, WB) control FSM for a multicycle
//   RV32-style datapath. An opcode is accepted in IDLE. The datapath controls
//   ALUOp/ALUSrc/MemtoReg are held for the whole instruction. Branch and Jump
//   pulse in EXEC, RegWrite pulses in WB, and mem_req is held through MEM
//   until mem_ack or the wait limit is reached.
//
//   Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//     defined   - an unknown opcode sets a sticky 'illegal' flag (cleared by
//                 reset only).
//     undefined - an unknown opcode is a NOP and 'illegal' is tied to 0.
//
// Parameters
//   MEM_TIMEOUT  maximum MEM-state cycles to wait for mem_ack (2..255)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   instr_valid  a new opcode is offered
//   Opcode[6:0]  instruction bits 6:0, sampled on the accept cycle only
//   instr_ready  high exactly while in IDLE (combinational)
//   mem_ack      data-memory completion strobe (honoured only in MEM)
//   mem_req      data-memory request (registered)
//   mem_we       data-memory write enable (registered)
//   ALUOp[1:0]   00 LW/SW/AUIPC/JALR, 01 branch, 10 R/I ALU, 11 JAL/LUI
//   ALUSrc, MemtoReg, Branch, Jump, RegWrite   datapath controls (registered)
//   mem_timeout  one-cycle pulse when the MEM wait limit expires
//   illegal      sticky unknown-opcode flag (0 unless the trap is enabled)
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [6:0] Opcode,
    output logic       instr_ready,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] ALUOp,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       Branch,
    output logic       Jump,
    output logic       RegWrite,
    output logic       mem_timeout,
    output logic       illegal
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // Value of the wait counter during the last permitted MEM cycle.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] aluop;
        logic       alusrc;
        logic       memtoreg;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_R:     d = '{1'b1, 2'b10, 1'b0, 1'b0};
            OP_I:     d = '{1'b1, 2'b10, 1'b1, 1'b0};
            OP_LW:    d = '{1'b1, 2'b00, 1'b1, 1'b1};
            OP_SW:    d = '{1'b1, 2'b00, 1'b1, 1'b0};
            OP_BR:    d = '{1'b1, 2'b01, 1'b0, 1'b0};
            OP_JAL:   d = '{1'b1, 2'b11, 1'b0, 1'b0};
            OP_LUI:   d = '{1'b1, 2'b11, 1'b1, 1'b0};
            OP_AUIPC: d = '{1'b1, 2'b00, 1'b1, 1'b0};
            OP_JALR:  d = '{1'b1, 2'b00, 1'b1, 1'b0};
            default:  d = '0;
        endcase
        return d;
    endfunction

    state_t     state, state_n;
    logic [6:0] op_q, op_n;
    logic [7:0] wait_cnt, wait_n;
    logic [1:0] aluop_n;
    logic       alusrc_n, memtoreg_n, branch_n, jump_n, regwrite_n;
    logic       mem_req_n, mem_we_n, mem_timeout_n;
    logic       illegal_q, illegal_n;
    dec_t       dec_in, dec_q;

    assign dec_in      = decode(Opcode);
    assign dec_q       = decode(op_q);
    assign instr_ready = (state == IDLE);

    always_comb begin
        state_n       = state;
        op_n          = op_q;
        wait_n        = wait_cnt;
        aluop_n       = ALUOp;
        alusrc_n      = ALUSrc;
        memtoreg_n    = MemtoReg;
        branch_n      = 1'b0;
        jump_n        = 1'b0;
        regwrite_n    = 1'b0;
        mem_req_n     = 1'b0;
        mem_we_n      = 1'b0;
        mem_timeout_n = 1'b0;
        illegal_n     = illegal_q;

        case (state)
            IDLE: begin
                if (instr_valid) begin
                    // Held controls come from the opcode being latched, so
                    // they are already valid while the FSM sits in DECODE.
                    op_n       = Opcode;
                    aluop_n    = dec_in.aluop;
                    alusrc_n   = dec_in.alusrc;
                    memtoreg_n = dec_in.memtoreg;
                    state_n    = DECODE;
                end
            end
            DECODE: begin
                if (!dec_q.legal) begin
                    state_n    = IDLE;
                    aluop_n    = 2'b00;
                    alusrc_n   = 1'b0;
                    memtoreg_n = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    illegal_n  = 1'b1;
`endif
                end else begin
                    state_n  = EXEC;
                    branch_n = (op_q == OP_BR);
                    jump_n   = (op_q == OP_JAL) || (op_q == OP_JALR);
                end
            end
            EXEC: begin
                if ((op_q == OP_LW) || (op_q == OP_SW)) begin
                    state_n   = MEM;
                    wait_n    = 8'd0;
                    mem_req_n = 1'b1;
                    mem_we_n  = (op_q == OP_SW);
                end else if (op_q == OP_BR) begin
                    state_n    = IDLE;
                    aluop_n    = 2'b00;
                    alusrc_n   = 1'b0;
                    memtoreg_n = 1'b0;
                end else begin
                    state_n    = WB;
                    regwrite_n = 1'b1;
                end
            end
            MEM: begin
                // An ack in the expiry cycle is checked first so that it wins.
                if (mem_ack) begin
                    if (op_q == OP_LW) begin
                        state_n    = WB;
                        regwrite_n = 1'b1;
                    end else begin
                        state_n    = IDLE;
                        aluop_n    = 2'b00;
                        alusrc_n   = 1'b0;
                        memtoreg_n = 1'b0;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n       = IDLE;
                    mem_timeout_n = 1'b1;
                    aluop_n       = 2'b00;
                    alusrc_n      = 1'b0;
                    memtoreg_n    = 1'b0;
                end else begin
                    wait_n    = wait_cnt + 8'd1;
                    mem_req_n = 1'b1;
                    mem_we_n  = (op_q == OP_SW);
                end
            end
            WB: begin
                state_n    = IDLE;
                aluop_n    = 2'b00;
                alusrc_n   = 1'b0;
                memtoreg_n = 1'b0;
            end
            default: begin
                state_n    = IDLE;
                aluop_n    = 2'b00;
                alusrc_n   = 1'b0;
                memtoreg_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= 7'd0;
            wait_cnt    <= 8'd0;
            ALUOp       <= 2'b00;
            ALUSrc      <= 1'b0;
            MemtoReg    <= 1'b0;
            Branch      <= 1'b0;
            Jump        <= 1'b0;
            RegWrite    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_timeout <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state       <= state_n;
            op_q        <= op_n;
            wait_cnt    <= wait_n;
            ALUOp       <= aluop_n;
            ALUSrc      <= alusrc_n;
            MemtoReg    <= memtoreg_n;
            Branch      <= branch_n;
            Jump        <= jump_n;
            RegWrite    <= regwrite_n;
            mem_req     <= mem_req_n;
            mem_we      <= mem_we_n;
            mem_timeout <= mem_timeout_n;
            illegal_q   <= illegal_n;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Self-checking bench for multicycle_controller. Each instruction's expected
//   per-cycle output trace is computed from the opcode class, the cycle count
//   after acceptance and the chosen mem_ack delay.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic [6:0] Opcode;
    logic       instr_ready;
    logic       mem_ack;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] ALUOp;
    logic       ALUSrc;
    logic       MemtoReg;
    logic       Branch;
    logic       Jump;
    logic       RegWrite;
    logic       mem_timeout;
    logic       illegal;

    int checks = 0;
    int errors = 0;
    bit ill_sticky = 0;

    // Instruction classes
    localparam int K_BAD = 0, K_ALU = 1, K_JMP = 2, K_BR = 3, K_LW = 4, K_SW = 5;

    multicycle_controller #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .Opcode(Opcode),
        .instr_ready(instr_ready), .mem_ack(mem_ack), .mem_req(mem_req),
        .mem_we(mem_we), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .Branch(Branch), .Jump(Jump), .RegWrite(RegWrite),
        .mem_timeout(mem_timeout), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Observed outputs: {rdy, ALUOp, ALUSrc, MemtoReg, Branch, Jump, RegWrite,
    //                    mem_req, mem_we, mem_timeout, illegal}
    wire [11:0] obs = {instr_ready, ALUOp, ALUSrc, MemtoReg, Branch, Jump,
                       RegWrite, mem_req, mem_we, mem_timeout, illegal};

    // Opcode table: class and held controls.
    task automatic classify(input logic [6:0] op, output int kind,
                            output logic [1:0] a, output logic s, output logic m);
        kind = K_BAD; a = 2'b00; s = 1'b0; m = 1'b0;
        case (op)
            7'b0110011: begin kind = K_ALU; a = 2'b10; end
            7'b0010011: begin kind = K_ALU; a = 2'b10; s = 1; end
            7'b0000011: begin kind = K_LW;  s = 1; m = 1; end
            7'b0100011: begin kind = K_SW;  s = 1; end
            7'b1100011: begin kind = K_BR;  a = 2'b01; end
            7'b1101111: begin kind = K_JMP; a = 2'b11; end
            7'b0110111: begin kind = K_ALU; a = 2'b11; s = 1; end
            7'b0010111: begin kind = K_ALU; s = 1; end
            7'b1100111: begin kind = K_JMP; s = 1; end
            default:    kind = K_BAD;
        endcase
    endtask

    // Runs one instruction from IDLE. d = MEM cycle index carrying mem_ack
    // (d >= T means mem_ack is never given). Starts and ends after a negedge
    // with the DUT idle. hold_valid keeps instr_valid high while busy.
    task automatic run_instr(input logic [6:0] op, input int d, input bit hold_valid,
                             input string tag);
        int kind, L, n;
        logic [1:0] ea;
        logic es, em;
        bit ack_ok, is_mem, hold, rw, mreq;
        logic [11:0] exp_v;
        classify(op, kind, ea, es, em);
        is_mem = (kind == K_LW) || (kind == K_SW);
        ack_ok = (d < T);
        n = ack_ok ? d + 1 : T;
        case (kind)
            K_BAD:   L = 2;
            K_BR:    L = 3;
            K_SW:    L = 3 + n;
            K_LW:    L = ack_ok ? 4 + n : 3 + n;
            default: L = 4;
        endcase
        instr_valid = 1'b1;
        Opcode = op;
        mem_ack = 1'($urandom);
        @(posedge clk);
        for (int c = 1; c <= L; c++) begin
            #1;
            instr_valid = (c < L) ? (hold_valid ? 1'b1 : 1'($urandom)) : 1'b0;
            Opcode = 7'($urandom);
            if (is_mem && c >= 3 && c < 3 + n)
                mem_ack = ack_ok && (c == 3 + d);
            else
                mem_ack = 1'($urandom);
            @(negedge clk);
            hold = (c < L);
            rw = ((kind == K_ALU || kind == K_JMP) && c == 3) ||
                 (kind == K_LW && ack_ok && c == 3 + n);
            mreq = is_mem && c >= 3 && c < 3 + n;
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (kind == K_BAD && c == 2) ill_sticky = 1;
`endif
            exp_v = {(c == L), hold ? ea : 2'b00, hold & es, hold & em,
                     (kind == K_BR && c == 2), (kind == K_JMP && c == 2), rw,
                     mreq, mreq && (kind == K_SW),
                     (is_mem && !ack_ok && c == L), ill_sticky};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s op=%b d=%0d cycle %0d: outputs got %b expected %b",
                         tag, op, d, c, obs, exp_v);
            end
            if (c < L) @(posedge clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_valid = 1'b1;
        Opcode = 7'b0110011;
        mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 12'b1000_0000_0000) begin
            errors++;
            $display("FAIL reset_state: outputs got %b expected %b", obs, 12'b1000_0000_0000);
        end
        instr_valid = 1'b0;
        mem_ack = 1'b0;
        rst_n = 1'b1;
        ill_sticky = 0;
        @(negedge clk);
        checks++;
        if (obs !== 12'b1000_0000_0000) begin
            errors++;
            $display("FAIL reset_release_idle: outputs got %b expected %b", obs, 12'b1000_0000_0000);
        end
    endtask

    task automatic test_rtype();
        run_instr(7'b0110011, 0, 1'b0, "rtype");
        run_instr(7'b0010011, 0, 1'b0, "itype");
        run_instr(7'b0110111, 0, 1'b0, "lui");
        run_instr(7'b0010111, 0, 1'b0, "auipc");
        run_instr(7'b1101111, 0, 1'b0, "jal");
        run_instr(7'b1100111, 0, 1'b0, "jalr");
    endtask

    task automatic test_mem();
        run_instr(7'b0000011, 2, 1'b0, "lw_ack2");
        run_instr(7'b0100011, T + 5, 1'b0, "sw_timeout");
        run_instr(7'b0000011, T - 1, 1'b0, "lw_ack_at_expiry");
        run_instr(7'b0100011, T - 1, 1'b0, "sw_ack_at_expiry");
        run_instr(7'b0000011, T - 2, 1'b0, "lw_ack_before_expiry");
        run_instr(7'b0000011, T + 1, 1'b0, "lw_timeout");
        run_instr(7'b0100011, 0, 1'b0, "sw_ack0");
    endtask

    task automatic test_branch_held_valid();
        run_instr(7'b1100011, 0, 1'b1, "branch_held_valid");
        run_instr(7'b0110011, 0, 1'b1, "rtype_held_valid");
    endtask

    task automatic test_illegal();
        run_instr(7'b1111111, 0, 1'b0, "illegal_op");
        // The flag (if enabled) must persist across later legal instructions.
        run_instr(7'b0110011, 0, 1'b0, "after_illegal");
        run_instr(7'b0000000, 0, 1'b0, "illegal_zero");
    endtask

    task automatic test_back_to_back();
        logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                      7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111,
                                      7'b1100111};
        logic [6:0] op;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 8)];
            else op = 7'($urandom);
            run_instr(op, int'($urandom_range(0, T + 2)), 1'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_mem();
        instr_valid = 1'b1;
        Opcode = 7'b0000011;
        mem_ack = 1'b0;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem_req: mem_req got %b expected 1", mem_req);
        end
        #2 rst_n = 1'b0;
        ill_sticky = 0;
        #1;
        checks++;
        if (obs !== 12'b1000_0000_0000) begin
            errors++;
            $display("FAIL reset_abort_immediate: outputs got %b expected %b", obs, 12'b1000_0000_0000);
        end
        mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== 12'b1000_0000_0000) begin
            errors++;
            $display("FAIL reset_abort_held: outputs got %b expected %b", obs, 12'b1000_0000_0000);
        end
        mem_ack = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 12'b1000_0000_0000) begin
            errors++;
            $display("FAIL reset_abort_release: outputs got %b expected %b", obs, 12'b1000_0000_0000);
        end
        run_instr(7'b0110011, 0, 1'b0, "after_abort");
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0;
        Opcode = 7'd0;
        mem_ack = 1'b0;
        test_reset();
        test_rtype();
        test_mem();
        test_branch_held_valid();
        test_illegal();
        test_back_to_back();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
